// File: rtl/div_fmt_pkg.sv
// Shared definitions for the divider BCD formatter: FSM encoding, iteration
// count and the active-low 7-segment code table.
package div_fmt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int ITER = 8;

  // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    logic [6:0] code;
    case (d)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// One 7-segment digit decoder. In error mode a digit of 4'hE shows 'E' and
// anything else shows 'r'; polarity is selected by active_low.
module bcd_to_7seg
  import div_fmt_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  input  logic       err_char,
  input  logic       active_low,
  output logic [6:0] seg
);

  logic [6:0] code;

  always_comb begin
    code = SEG_BLANK;
    if (err_char) begin
      code = (digit == 4'hE) ? SEG_E : SEG_R;
    end else if (!blank) begin
      code = digit_seg(digit);
    end
  end

  assign seg = active_low ? code : ~code;

endmodule

// File: rtl/div_bcd_formatter.sv
// Captures the divider result on start, converts the quotient to BCD with a
// one-shift-per-cycle double-dabble and drives three 7-segment displays.
module div_bcd_formatter
  import div_fmt_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit BLANK_LEADING  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] S,
  input  logic       R_exists,
  input  logic       ERRO,
  output logic       busy,
  output logic       done,
  output logic [3:0] bcd_h,
  output logic [3:0] bcd_t,
  output logic [3:0] bcd_u,
  output logic       err_out,
  output logic       rem_out,
  output logic [6:0] hex2,
  output logic [6:0] hex1,
  output logic [6:0] hex0
);

  state_t      state, state_nxt;
  logic [2:0]  cnt;
  logic [7:0]  bin_q;
  logic [11:0] scr_q;
  logic        rem_q, err_q;

  logic [11:0] adj;
  logic [19:0] work;
  logic [11:0] scr_nxt;
  logic [7:0]  bin_nxt;
  logic        last_shift;

  assign last_shift = (state == SHIFT) && (cnt == 3'(ITER - 1));

  // Double-dabble step: add 3 to every nibble >= 5, then shift {bcd,bin} left.
  always_comb begin
    adj = scr_q;
    for (int i = 0; i < 3; i++) begin
      if (scr_q[i*4 +: 4] >= 4'd5) begin
        adj[i*4 +: 4] = scr_q[i*4 +: 4] + 4'd3;
      end
    end
    work    = {adj, bin_q} << 1;
    scr_nxt = work[19:8];
    bin_nxt = work[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_shift) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == SHIFT) || (state == DONE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= 3'd0;
      bin_q   <= 8'd0;
      scr_q   <= 12'd0;
      rem_q   <= 1'b0;
      err_q   <= 1'b0;
      bcd_h   <= 4'd0;
      bcd_t   <= 4'd0;
      bcd_u   <= 4'd0;
      err_out <= 1'b0;
      rem_out <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        bin_q <= S;
        rem_q <= R_exists;
        err_q <= ERRO;
        scr_q <= 12'd0;
        cnt   <= 3'd0;
      end else if (state == SHIFT) begin
        scr_q <= scr_nxt;
        bin_q <= bin_nxt;
        cnt   <= cnt + 3'd1;
        // The conversion still runs on an error so latency never changes.
        if (last_shift) begin
          bcd_h   <= err_q ? 4'd0 : scr_nxt[11:8];
          bcd_t   <= err_q ? 4'd0 : scr_nxt[7:4];
          bcd_u   <= err_q ? 4'd0 : scr_nxt[3:0];
          err_out <= err_q;
          rem_out <= rem_q & ~err_q;
        end
      end
    end
  end

  logic       blank_h, blank_t;
  logic [3:0] dig_h, dig_t, dig_u;

  assign blank_h = BLANK_LEADING && (bcd_h == 4'd0);
  assign blank_t = BLANK_LEADING && (bcd_h == 4'd0) && (bcd_t == 4'd0);
  assign dig_h   = err_out ? 4'hE : bcd_h;
  assign dig_t   = err_out ? 4'hF : bcd_t;
  assign dig_u   = err_out ? 4'hF : bcd_u;

  bcd_to_7seg u_seg_h (
    .digit(dig_h), .blank(blank_h), .err_char(err_out),
    .active_low(SEG_ACTIVE_LOW), .seg(hex2)
  );

  bcd_to_7seg u_seg_t (
    .digit(dig_t), .blank(blank_t), .err_char(err_out),
    .active_low(SEG_ACTIVE_LOW), .seg(hex1)
  );

  bcd_to_7seg u_seg_u (
    .digit(dig_u), .blank(1'b0), .err_char(err_out),
    .active_low(SEG_ACTIVE_LOW), .seg(hex0)
  );

endmodule

// File: tb/tb_div_bcd_formatter.sv
// Directed bench for div_bcd_formatter with default parameters (active-low
// segments, leading-zero blanking); expected values are hand-computed.
module tb_div_bcd_formatter;

  localparam logic [6:0] C_0     = 7'b1000000;
  localparam logic [6:0] C_1     = 7'b1111001;
  localparam logic [6:0] C_2     = 7'b0100100;
  localparam logic [6:0] C_4     = 7'b0011001;
  localparam logic [6:0] C_5     = 7'b0010010;
  localparam logic [6:0] C_7     = 7'b1111000;
  localparam logic [6:0] C_8     = 7'b0000000;
  localparam logic [6:0] C_E     = 7'b0000110;
  localparam logic [6:0] C_R     = 7'b0101111;
  localparam logic [6:0] C_BLANK = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] S;
  logic       R_exists;
  logic       ERRO;
  logic       busy, done;
  logic [3:0] bcd_h, bcd_t, bcd_u;
  logic       err_out, rem_out;
  logic [6:0] hex2, hex1, hex0;

  int checks = 0;
  int errors = 0;

  div_bcd_formatter dut (
    .clk(clk), .rst_n(rst_n), .start(start), .S(S), .R_exists(R_exists),
    .ERRO(ERRO), .busy(busy), .done(done), .bcd_h(bcd_h), .bcd_t(bcd_t),
    .bcd_u(bcd_u), .err_out(err_out), .rem_out(rem_out),
    .hex2(hex2), .hex1(hex1), .hex0(hex0)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle a little after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start at the next edge, then wait (bounded) for done.
  task automatic run_conv(input logic [7:0] s_val, input logic r_val,
                          input logic e_val, output int lat);
    S        = s_val;
    R_exists = r_val;
    ERRO     = e_val;
    start    = 1'b1;
    tick();
    start = 1'b0;
    lat   = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; S = 8'd99; R_exists = 1'b1; ERRO = 1'b0;
    tick();
    tick();
    start = 1'b0;
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++; $display("[TB] FAIL reset_busy_done got %b exp 00", {busy, done});
    end
    checks++;
    if ({bcd_h, bcd_t, bcd_u, err_out, rem_out} !== 14'd0) begin
      errors++;
      $display("[TB] FAIL reset_regs got %h%h%h e%b r%b exp 000 e0 r0",
               bcd_h, bcd_t, bcd_u, err_out, rem_out);
    end
    checks++;
    if ({hex2, hex1, hex0} !== {C_BLANK, C_BLANK, C_0}) begin
      errors++; $display("[TB] FAIL reset_hex got %b %b %b exp %b %b %b",
                         hex2, hex1, hex0, C_BLANK, C_BLANK, C_0);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_wins_start got busy=%b exp 0", busy);
    end
  endtask

  task automatic test_max();
    int lat;
    run_conv(8'd255, 1'b0, 1'b0, lat);
    checks++;
    if (lat != 8) begin
      errors++; $display("[TB] FAIL max_latency got %0d exp 8", lat);
    end
    checks++;
    if ({bcd_h, bcd_t, bcd_u} !== 12'h255) begin
      errors++; $display("[TB] FAIL max_bcd got %h%h%h exp 255", bcd_h, bcd_t, bcd_u);
    end
    checks++;
    if ({hex2, hex1, hex0, rem_out, err_out} !== {C_2, C_5, C_5, 2'b00}) begin
      errors++; $display("[TB] FAIL max_hex got %b %b %b r%b e%b exp %b %b %b r0 e0",
                         hex2, hex1, hex0, rem_out, err_out, C_2, C_5, C_5);
    end
    tick();
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++; $display("[TB] FAIL max_done_pulse got %b exp 00", {busy, done});
    end
  endtask

  task automatic test_small_remainder();
    int lat;
    run_conv(8'd7, 1'b1, 1'b0, lat);
    checks++;
    if ({bcd_h, bcd_t, bcd_u} !== 12'h007 || lat != 8) begin
      errors++; $display("[TB] FAIL small_bcd got %h%h%h lat %0d exp 007 lat 8",
                         bcd_h, bcd_t, bcd_u, lat);
    end
    checks++;
    if ({hex2, hex1, hex0, rem_out} !== {C_BLANK, C_BLANK, C_7, 1'b1}) begin
      errors++; $display("[TB] FAIL small_hex got %b %b %b r%b exp %b %b %b r1",
                         hex2, hex1, hex0, rem_out, C_BLANK, C_BLANK, C_7);
    end
    tick();
  endtask

  task automatic test_hundred();
    int lat;
    run_conv(8'd100, 1'b0, 1'b0, lat);
    checks++;
    if ({bcd_h, bcd_t, bcd_u} !== 12'h100) begin
      errors++; $display("[TB] FAIL hundred_bcd got %h%h%h exp 100", bcd_h, bcd_t, bcd_u);
    end
    checks++;
    if ({hex2, hex1, hex0, rem_out} !== {C_1, C_0, C_0, 1'b0}) begin
      errors++; $display("[TB] FAIL hundred_hex got %b %b %b r%b exp %b %b %b r0",
                         hex2, hex1, hex0, rem_out, C_1, C_0, C_0);
    end
    tick();
  endtask

  task automatic test_error();
    int lat;
    run_conv(8'hFF, 1'b1, 1'b1, lat);
    checks++;
    if (lat != 8) begin
      errors++; $display("[TB] FAIL err_latency got %0d exp 8", lat);
    end
    checks++;
    if ({bcd_h, bcd_t, bcd_u, err_out, rem_out} !== {12'h000, 2'b10}) begin
      errors++; $display("[TB] FAIL err_regs got %h%h%h e%b r%b exp 000 e1 r0",
                         bcd_h, bcd_t, bcd_u, err_out, rem_out);
    end
    checks++;
    if ({hex2, hex1, hex0} !== {C_E, C_R, C_R}) begin
      errors++; $display("[TB] FAIL err_hex got %b %b %b exp %b %b %b",
                         hex2, hex1, hex0, C_E, C_R, C_R);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int done_count = 0;
    S = 8'd58; R_exists = 1'b0; ERRO = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    S = 8'd99; R_exists = 1'b1; ERRO = 1'b1;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("[TB] FAIL b2b_busy got %b exp 1", busy);
    end
    for (int c = 1; c <= 16; c++) begin
      start = (c == 2 || c == 5);
      tick();
      if (done === 1'b1) done_count++;
    end
    start = 1'b0;
    checks++;
    if (done_count != 1) begin
      errors++; $display("[TB] FAIL b2b_done_count got %0d exp 1", done_count);
    end
    checks++;
    if ({bcd_h, bcd_t, bcd_u, err_out, rem_out} !== {12'h058, 2'b00}) begin
      errors++; $display("[TB] FAIL b2b_result got %h%h%h e%b r%b exp 058 e0 r0",
                         bcd_h, bcd_t, bcd_u, err_out, rem_out);
    end
    checks++;
    if ({hex2, hex1, hex0} !== {C_BLANK, C_5, C_8}) begin
      errors++; $display("[TB] FAIL b2b_hex got %b %b %b exp %b %b %b",
                         hex2, hex1, hex0, C_BLANK, C_5, C_8);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int done_count = 0;
    S = 8'd123; R_exists = 1'b1; ERRO = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({busy, done, bcd_h, bcd_t, bcd_u, err_out, rem_out} !== 16'd0) begin
      errors++; $display("[TB] FAIL midreset_state got b%b d%b %h%h%h e%b r%b exp all 0",
                         busy, done, bcd_h, bcd_t, bcd_u, err_out, rem_out);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done === 1'b1) done_count++;
    end
    checks++;
    if (done_count != 0) begin
      errors++; $display("[TB] FAIL midreset_no_done got %0d exp 0", done_count);
    end
    run_conv(8'd42, 1'b0, 1'b0, lat);
    checks++;
    if ({bcd_h, bcd_t, bcd_u} !== 12'h042 || lat != 8) begin
      errors++; $display("[TB] FAIL midreset_fresh got %h%h%h lat %0d exp 042 lat 8",
                         bcd_h, bcd_t, bcd_u, lat);
    end
    checks++;
    if ({hex2, hex1, hex0} !== {C_BLANK, C_4, C_2}) begin
      errors++; $display("[TB] FAIL midreset_hex got %b %b %b exp %b %b %b",
                         hex2, hex1, hex0, C_BLANK, C_4, C_2);
    end
    tick();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; S = 8'd0; R_exists = 1'b0; ERRO = 1'b0;
    test_reset();
    test_max();
    test_small_remainder();
    test_hundred();
    test_error();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
